// File: rtl/digit_serial_subtractor_pkg.sv
// Shared constants, FSM state type and overflow helper for the digit-serial subtractor.
package sub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Overflow happens when the operand signs differ and the result sign departs from X.
  function automatic logic signed_of(input logic xm, input logic ym, input logic dm);
    return (xm != ym) && (dm != xm);
  endfunction

endpackage

// File: rtl/digit_serial_subtractor_digit.sv
// DIGIT-bit combinational borrow-ripple slice: d = a - b - bin, built as a + ~b + ~bin.
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] c;

  assign c[0] = ~bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign d[i]   = a[i] ^ ~b[i] ^ c[i];
    assign c[i+1] = (a[i] & ~b[i]) | (a[i] & c[i]) | (~b[i] & c[i]);
  end

  assign bout = ~c[DIGIT];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Digit-serial X - Y - Bin with valid/ready on both sides; one DIGIT-bit slice reused per cycle.
module digit_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             OF
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("DIGIT must divide WIDTH evenly");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, y_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, bout_q, of_q;

  logic [DIGIT-1:0] dig_a, dig_b, dig_d;
  logic             dig_bout, last_dig;

  assign last_dig = (cnt_q == CW'(NDIG - 1));
  assign dig_a    = x_q[cnt_q*DIGIT +: DIGIT];
  assign dig_b    = y_q[cnt_q*DIGIT +: DIGIT];

  digit_subtractor #(.DIGIT(DIGIT)) u_slice (
    .a    (dig_a),
    .b    (dig_b),
    .bin  (brw_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_dig)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Operands need no reset: they are only read after being loaded on accept.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      x_q <= X;
      y_q <= Y;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      of_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          cnt_q <= '0;
          brw_q <= Bin;
        end
        RUN: begin
          d_q[cnt_q*DIGIT +: DIGIT] <= dig_d;
          brw_q                     <= dig_bout;
          cnt_q                     <= last_dig ? '0 : cnt_q + CW'(1);
          if (last_dig) begin
            bout_q <= dig_bout;
            of_q   <= signed_of(x_q[WIDTH-1], y_q[WIDTH-1], dig_d[DIGIT-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign OF   = of_q;

endmodule
